mult_arbiter: RTL

Sequencer and two-way round-robin arbiter that shares the single iterative Booth multiplier between two requesters (e.g. the execute stage and a coprocessor port). It latches the winning requester's operands, restarts the multiplier with a one-cycle reset pulse, waits for its ready flag, captures result and overflow, and returns them with a done pulse. A watchdog aborts any operation whose ready never arrives.

---
 rtl/mult_arbiter_pkg.sv | 14 +
 rtl/mult_arbiter_rr_arbiter2.sv | 15 +
 rtl/mult_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mult_arbiter_pkg.sv
// Shared encodings and defaults for the multiplier-sharing arbiter.
package mult_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   localparam int WIDTH_DEF   = 32;
   localparam int TIMEOUT_DEF = 40;

endpackage

// File: rtl/mult_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module rr_arbiter2 (
   input  logic req_0,
   input  logic req_1,
   input  logic last_grant,
   output logic winner,
   output logic valid
);

   always_comb begin
      valid  = req_0 | req_1;
      winner = (req_0 && req_1) ? ~last_grant : req_1;
   end

endmodule

// File: rtl/mult_arbiter.sv
// Sequencer sharing one iterative multiplier between two requesters,
// with round-robin arbitration and a RUN-state watchdog.
module mult_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_0,
   input  logic             req_1,
   input  logic [WIDTH-1:0] multiplicand_0,
   input  logic [WIDTH-1:0] multiplier_0,
   input  logic [WIDTH-1:0] multiplicand_1,
   input  logic [WIDTH-1:0] multiplier_1,
   output logic             grant_0,
   output logic             grant_1,
   output logic             done_0,
   output logic             done_1,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             error,
   output logic             busy,
   output logic [WIDTH-1:0] mult_multiplicand,
   output logic [WIDTH-1:0] mult_multiplier,
   output logic             mult_reset,
   input  logic [WIDTH-1:0] mult_result,
   input  logic             mult_overflow,
   input  logic             mult_ready
);

   // state | meaning
   // IDLE  | waiting for a request; arbitrate and latch operands
   // LOAD  | grant pulse, multiplier restart pulse
   // RUN   | waiting for mult_ready, watchdog counting down
   // DONE  | done pulse to owner, result/overflow/error valid

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

   state_t           state;
   logic             owner;
   logic             last_grant;
   logic [WD_W-1:0]  wd_cnt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             arb_winner;
   logic             arb_valid;
   logic             first_run;

   rr_arbiter2 u_rr (
      .req_0      (req_0),
      .req_1      (req_1),
      .last_grant (last_grant),
      .winner     (arb_winner),
      .valid      (arb_valid)
   );

   assign mult_multiplicand = op_a;
   assign mult_multiplier   = op_b;

   // The counter still holds its load value only in the first RUN cycle,
   // when a ready left over from the previous operation may be visible.
   assign first_run = (wd_cnt == WD_LOAD);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         wd_cnt     <= '0;
         op_a       <= '0;
         op_b       <= '0;
         grant_0    <= 1'b0;
         grant_1    <= 1'b0;
         done_0     <= 1'b0;
         done_1     <= 1'b0;
         mult_reset <= 1'b0;
         result     <= '0;
         overflow   <= 1'b0;
         error      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         grant_0    <= 1'b0;
         grant_1    <= 1'b0;
         done_0     <= 1'b0;
         done_1     <= 1'b0;
         mult_reset <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (arb_valid) begin
                  op_a       <= arb_winner ? multiplicand_1 : multiplicand_0;
                  op_b       <= arb_winner ? multiplier_1   : multiplier_0;
                  owner      <= arb_winner;
                  last_grant <= arb_winner;
                  grant_0    <= ~arb_winner;
                  grant_1    <= arb_winner;
                  mult_reset <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               wd_cnt <= WD_LOAD;
               state  <= ST_RUN;
            end
            ST_RUN: begin
               if (mult_ready && !first_run) begin
                  result   <= mult_result;
                  overflow <= mult_overflow;
                  error    <= 1'b0;
                  done_0   <= ~owner;
                  done_1   <= owner;
                  state    <= ST_DONE;
               end else if (wd_cnt == '0) begin
                  result   <= '0;
                  overflow <= 1'b0;
                  error    <= 1'b1;
                  done_0   <= ~owner;
                  done_1   <= owner;
                  state    <= ST_DONE;
               end else begin
                  wd_cnt <= wd_cnt - WD_W'(1);
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
